// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter
// Host/arbiter end of the DMA br/bg handshake. A CPU transfer command is
// handed to the DMA controller as a one-cycle dma_cmd pulse. The start address
// is driven on the shared address bus for the CMD and ADDR cycles. Each bus
// request then gets a fixed-length grant window, with the CPU stalled for the
// duration of the window. Completion is flagged when the DMA controller lets br
// fall during a gap between grants.
//
// GAP_CYCLES must be at least 2. The DMA controller needs two edges to update
// br after bg falls.

module dma_bus_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int BURST_CYCLES = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cmd_valid,
    input  logic [WORD_SIZE-1:0]   cmd_addr,
    input  logic [4*WORD_SIZE-1:0] cmd_length,
    output logic                   cmd_ready,
    output logic                   cmd_error,
    output logic                   dma_cmd,
    output logic [4*WORD_SIZE-1:0] dma_length,
    inout  wire  [WORD_SIZE-1:0]   address,
    input  logic                   br,
    output logic                   bg,
    input  logic                   cpu_mem_busy,
    output logic                   cpu_stall,
    output logic [WORD_SIZE-1:0]   burst_count,
    output logic                   done_irq
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CMD      = 3'd1;
    localparam logic [2:0] S_ADDR     = 3'd2;
    localparam logic [2:0] S_WAIT_BR  = 3'd3;
    localparam logic [2:0] S_WAIT_CPU = 3'd4;
    localparam logic [2:0] S_GRANT    = 3'd5;
    localparam logic [2:0] S_GAP      = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    // One shared timer serves both the grant window and the gap.
    localparam int TMAX = (BURST_CYCLES > GAP_CYCLES) ? BURST_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] BURST_LAST = TW'(BURST_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);

    logic [2:0]             r_state;
    logic [TW-1:0]          r_timer;
    logic [WORD_SIZE-1:0]   r_addr;
    logic                   r_addr_oe;
    logic [4*WORD_SIZE-1:0] r_dma_length;
    logic                   r_dma_cmd;
    logic                   r_bg;
    logic                   r_cmd_error;
    logic                   r_done_irq;
    logic [WORD_SIZE-1:0]   r_burst_count;

    // Only the low word of the length is meaningful. Below one block is rejected.
    logic w_len_ok;
    assign w_len_ok = (cmd_length[WORD_SIZE-1:0] >= WORD_SIZE'(4));

    // Control FSM. Every output is a flop, so bg and the bus enable cannot glitch.
    // Both are set or cleared on state-entry edges. They are never high together,
    // because ADDR always passes through WAIT_BR before any grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_addr        <= '0;
            r_addr_oe     <= 1'b0;
            r_dma_length  <= '0;
            r_dma_cmd     <= 1'b0;
            r_bg          <= 1'b0;
            r_cmd_error   <= 1'b0;
            r_done_irq    <= 1'b0;
            r_burst_count <= '0;
        end else begin
            // NOTE: pulse outputs default low here so each is high for exactly the one
            // cycle after the edge that sets it. Non-blocking assignment lets this
            // default coexist with the later override in the same block.
            r_dma_cmd   <= 1'b0;
            r_cmd_error <= 1'b0;
            r_done_irq  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (w_len_ok) begin
                            r_addr        <= cmd_addr;
                            r_dma_length  <= cmd_length;
                            r_burst_count <= '0;
                            r_addr_oe     <= 1'b1;
                            r_dma_cmd     <= 1'b1;
                            r_state       <= S_CMD;
                        end else begin
                            r_cmd_error <= 1'b1;
                        end
                    end
                end
                S_CMD: begin
                    r_state <= S_ADDR;
                end
                S_ADDR: begin
                    // The DMA controller samples the address on this edge. Let go of the bus after it.
                    r_addr_oe <= 1'b0;
                    r_state   <= S_WAIT_BR;
                end
                S_WAIT_BR: begin
                    if (br) begin
                        r_state <= S_WAIT_CPU;
                    end
                end
                S_WAIT_CPU: begin
                    // An in-flight CPU access always completes before the bus is handed over.
                    if (!cpu_mem_busy) begin
                        r_bg    <= 1'b1;
                        r_timer <= '0;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // br is not looked at here. A granted window always runs to full length.
                    if (r_timer == BURST_LAST) begin
                        r_bg          <= 1'b0;
                        r_timer       <= '0;
                        r_burst_count <= r_burst_count + 1'b1;
                        r_state       <= S_GAP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_timer == GAP_LAST) begin
                        r_timer <= '0;
                        if (br) begin
                            r_state <= S_WAIT_CPU;
                        end else begin
                            r_done_irq <= 1'b1;
                            r_state    <= S_DONE;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_bg      <= 1'b0;
                    r_addr_oe <= 1'b0;
                end
            endcase
        end
    end

    assign address     = r_addr_oe ? r_addr : {WORD_SIZE{1'bz}};
    assign cmd_ready   = (r_state == S_IDLE);
    assign cmd_error   = r_cmd_error;
    assign dma_cmd     = r_dma_cmd;
    assign dma_length  = r_dma_length;
    assign bg          = r_bg;
    assign cpu_stall   = r_bg;
    assign burst_count = r_burst_count;
    assign done_irq    = r_done_irq;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb_dma_bus_arbiter
// Directed bench for dma_bus_arbiter. A bench-side driver holds a sentinel value
// on the address bus whenever the arbiter should have released it. Contention
// therefore shows up as a corrupted value. A negedge monitor checks the grant
// and gap lengths, and checks that the bus stays clean while bg is high.

module tb_dma_bus_arbiter;

    localparam logic [15:0] SENT = 16'hA5A5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic [15:0] cmd_addr;
    logic [63:0] cmd_length;
    logic        br;
    logic        cpu_mem_busy;
    logic        tb_drv_en;

    logic        cmd_ready;
    logic        cmd_error;
    logic        dma_cmd;
    logic [63:0] dma_length;
    logic        bg;
    logic        cpu_stall;
    logic [15:0] burst_count;
    logic        done_irq;
    wire  [15:0] address;

    assign address = tb_drv_en ? SENT : 16'hzzzz;

    int n_checks = 0;
    int n_errors = 0;

    dma_bus_arbiter #(
        .WORD_SIZE    (16),
        .BURST_CYCLES (4),
        .GAP_CYCLES   (2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_addr     (cmd_addr),
        .cmd_length   (cmd_length),
        .cmd_ready    (cmd_ready),
        .cmd_error    (cmd_error),
        .dma_cmd      (dma_cmd),
        .dma_length   (dma_length),
        .address      (address),
        .br           (br),
        .bg           (bg),
        .cpu_mem_busy (cpu_mem_busy),
        .cpu_stall    (cpu_stall),
        .burst_count  (burst_count),
        .done_irq     (done_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus monitor: grant window length, minimum gap, no contention while granted.
    logic mon_prev_bg = 1'b0;
    int   mon_run     = 0;
    int   mon_gap     = 99;

    always @(negedge clk) begin
        if (!reset_n) begin
            mon_prev_bg = 1'b0;
            mon_run     = 0;
            mon_gap     = 99;
        end else begin
            if (bg) begin
                if (!mon_prev_bg) begin
                    check("gap_len_min", 64'(mon_gap >= 2), 64'(1));
                    mon_run = 0;
                end
                mon_run++;
                check("bus_clean_in_grant", 64'(address), 64'(SENT));
            end else begin
                if (mon_prev_bg) begin
                    check("burst_len", 64'(mon_run), 64'(4));
                    mon_gap = 1;
                end else if (mon_gap < 99) begin
                    mon_gap++;
                end
            end
            mon_prev_bg = bg;
        end
    end

    // Accept a command and verify the CMD/ADDR bus phase.
    task automatic issue_cmd(input logic [15:0] a, input logic [63:0] l);
        cmd_addr   = a;
        cmd_length = l;
        cmd_valid  = 1'b1;
        tb_drv_en  = 1'b0;
        check("ready_idle", 64'(cmd_ready), 64'(1));
        tick();
        cmd_valid = 1'b0;
        check("dma_cmd_on", 64'(dma_cmd), 64'(1));
        check("addr_in_cmd", 64'(address), 64'(a));
        check("dma_length", dma_length, l);
        check("ready_low_busy", 64'(cmd_ready), 64'(0));
        check("bc_cleared", 64'(burst_count), 64'(0));
        tick();
        check("dma_cmd_off", 64'(dma_cmd), 64'(0));
        check("addr_in_addr", 64'(address), 64'(a));
        tick();
        tb_drv_en = 1'b1;
        #1;
        check("addr_released", 64'(address), 64'(SENT));
    endtask

    // Full transfer with a model DMA: br held until the expected grants are seen.
    task automatic run_transfer(input logic [15:0] a, input logic [63:0] l, input int busy_n,
                                input bit early_drop, input bit poke);
        int exp_g;
        int exp_first;
        int k;
        int first;
        int seen;
        int fall_k;
        int cur;
        bit done;
        logic prev;
        exp_g     = int'(l[15:0]) >> 2;
        exp_first = (busy_n > 1) ? busy_n + 1 : 2;
        issue_cmd(a, l);
        br           = 1'b1;
        cpu_mem_busy = (busy_n > 0);
        k = 0; first = -1; seen = 0; fall_k = -100; cur = 0; done = 1'b0; prev = 1'b0;
        while (!done && k < 200) begin
            tick();
            k++;
            cpu_mem_busy = (k < busy_n);
            cmd_valid    = 1'b0;
            check("stall_eq_bg", 64'(cpu_stall), 64'(bg));
            check("dma_cmd_quiet", 64'(dma_cmd), 64'(0));
            cur = bg ? (prev ? cur + 1 : 1) : 0;
            if (bg && first < 0) begin
                first = k;
                check("first_bg_latency", 64'(k), 64'(exp_first));
            end
            if (poke && seen == 0 && cur == 2) begin
                check("ready_low_in_grant", 64'(cmd_ready), 64'(0));
                cmd_valid  = 1'b1;
                cmd_addr   = 16'hFFF0;
                cmd_length = 64'd40;
            end
            if (early_drop && seen == exp_g - 1 && cur == 2) begin
                br = 1'b0;
            end
            if (prev && !bg) begin
                seen++;
                fall_k = k;
                check("bc_increment", 64'(burst_count), 64'(seen));
                if (seen == exp_g) begin
                    br = 1'b0;
                end
            end
            if (done_irq) begin
                done = 1'b1;
                check("done_latency", 64'(k - fall_k), 64'(2));
                check("grant_total", 64'(seen), 64'(exp_g));
                check("bc_final", 64'(burst_count), 64'(exp_g));
            end
            prev = bg;
        end
        cmd_valid = 1'b0;
        check("transfer_timeout", 64'(done), 64'(1));
        tick();
        check("done_single_pulse", 64'(done_irq), 64'(0));
        check("back_to_idle", 64'(cmd_ready), 64'(1));
        check("dma_length_kept", dma_length, l);
    endtask

    // Rejected command: error pulse only, no DMA activity.
    task automatic err_cmd(input logic [63:0] l);
        cmd_addr   = 16'h0BAD;
        cmd_length = l;
        cmd_valid  = 1'b1;
        check("err_ready_before", 64'(cmd_ready), 64'(1));
        tick();
        cmd_valid = 1'b0;
        check("err_pulse", 64'(cmd_error), 64'(1));
        check("err_no_dma_cmd", 64'(dma_cmd), 64'(0));
        check("err_ready_after", 64'(cmd_ready), 64'(1));
        tick();
        check("err_pulse_end", 64'(cmd_error), 64'(0));
        check("err_no_dma_cmd2", 64'(dma_cmd), 64'(0));
    endtask

    initial begin
        int w;
        reset_n      = 1'b0;
        cmd_valid    = 1'b0;
        cmd_addr     = '0;
        cmd_length   = '0;
        br           = 1'b0;
        cpu_mem_busy = 1'b0;
        tb_drv_en    = 1'b1;

        #12;
        check("rst_ready", 64'(cmd_ready), 64'(1));
        check("rst_bg", 64'(bg), 64'(0));
        check("rst_stall", 64'(cpu_stall), 64'(0));
        check("rst_dma_cmd", 64'(dma_cmd), 64'(0));
        check("rst_cmd_error", 64'(cmd_error), 64'(0));
        check("rst_done", 64'(done_irq), 64'(0));
        check("rst_bc", 64'(burst_count), 64'(0));
        check("rst_dma_length", dma_length, 64'(0));
        check("rst_addr_released", 64'(address), 64'(SENT));
        #5;
        reset_n = 1'b1;
        tick();

        // Basic transfer: three 4-word blocks.
        run_transfer(16'h0010, 64'd12, 0, 1'b0, 1'b0);

        // Rejected lengths, including one with only upper bits set.
        err_cmd(64'd2);
        err_cmd(64'd0);
        err_cmd(64'd3);
        err_cmd(64'h0000_0000_0001_0000);

        // CPU busy for five cycles after br rises.
        run_transfer(16'h0020, 64'd16, 5, 1'b0, 1'b0);

        // br dropped mid-grant, plus a command poked during a grant.
        run_transfer(16'h0030, 64'd8, 0, 1'b1, 1'b1);

        // Smallest legal transfer.
        run_transfer(16'h0100, 64'd4, 0, 1'b0, 1'b0);

        // Reset in the middle of the second grant.
        issue_cmd(16'h0200, 64'd12);
        br = 1'b1;
        w = 0;
        while (!(bg && burst_count == 16'd1) && w < 40) begin
            tick();
            w++;
        end
        check("reach_second_grant", 64'(bg && burst_count == 16'd1), 64'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_bg", 64'(bg), 64'(0));
        check("arst_stall", 64'(cpu_stall), 64'(0));
        check("arst_ready", 64'(cmd_ready), 64'(1));
        check("arst_bc", 64'(burst_count), 64'(0));
        check("arst_dma_length", dma_length, 64'(0));
        check("arst_addr", 64'(address), 64'(SENT));
        br = 1'b0;
        tick();
        tick();
        #3;
        reset_n = 1'b1;
        tick();

        // Transfer after reset; upper length bits are carried but not used.
        run_transfer(16'h0340, 64'hFFFF_0000_0000_0008, 0, 1'b0, 1'b0);

        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
